// File: rtl/dec_result_collector.sv
// Collects decoder results on each rising edge of found into a small FWFT FIFO.
// It also keeps saturating pass/fail/drop statistics and a sticky overflow flag.
module dec_result_collector #(
  parameter int W_BITS = 39,
  parameter int N_BITS = 25,
  parameter int DEPTH  = 4,
  parameter int EXP_N  = 16777215,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     found,
  input  logic [N_BITS-1:0]        N,
  input  logic [W_BITS-1:0]        W,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [W_BITS-1:0]        out_W,
  output logic [N_BITS-1:0]        out_N,
  output logic                     out_match,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         pass_cnt,
  output logic [CNT_W-1:0]         fail_cnt,
  output logic [CNT_W-1:0]         drop_cnt,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = W_BITS + N_BITS + 1;

  logic              found_d_r;
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [EW-1:0]     mem_r [DEPTH];

  logic              cap_s;
  logic              match_s;
  logic              pop_s;
  logic              full_s;
  logic              push_s;
  logic              drop_s;
  logic [EW-1:0]     entry_s;
  logic [AW-1:0]     wr_ptr_nxt_s;
  logic [AW-1:0]     rd_ptr_nxt_s;
  logic [LW-1:0]     level_nxt_s;
  logic [EW-1:0]     head_nxt_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (c == {CNT_W{1'b1}}) begin
      return c;
    end else begin
      return c + CNT_W'(1);
    end
  endfunction

  // Capture/pop decisions and next FIFO state, including the next head entry
  always_comb begin
    cap_s        = found & ~found_d_r;
    match_s      = (N == N_BITS'(EXP_N));
    pop_s        = out_valid & out_ready;
    full_s       = (level == LW'(DEPTH));
    push_s       = cap_s & (~full_s | pop_s);
    drop_s       = cap_s & full_s & ~pop_s;
    entry_s      = {W, N, match_s};
    wr_ptr_nxt_s = push_s ? wr_ptr_r + AW'(1) : wr_ptr_r;
    rd_ptr_nxt_s = pop_s ? rd_ptr_r + AW'(1) : rd_ptr_r;
    case ({push_s, pop_s})
      2'b10:   level_nxt_s = level + LW'(1);
      2'b01:   level_nxt_s = level - LW'(1);
      default: level_nxt_s = level;
    endcase
    // A push into the slot that becomes the head must bypass the array
    if (level_nxt_s == LW'(0)) begin
      head_nxt_s = {EW{1'b0}};
    end else if (push_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
      head_nxt_s = entry_s;
    end else begin
      head_nxt_s = mem_r[rd_ptr_nxt_s];
    end
  end

  // FIFO storage, pointers and registered head outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      found_d_r <= 1'b0;
      wr_ptr_r  <= AW'(0);
      rd_ptr_r  <= AW'(0);
      level     <= LW'(0);
      out_valid <= 1'b0;
      out_W     <= W_BITS'(0);
      out_N     <= N_BITS'(0);
      out_match <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {EW{1'b0}};
      end
    end else begin
      found_d_r <= found;
      wr_ptr_r  <= wr_ptr_nxt_s;
      rd_ptr_r  <= rd_ptr_nxt_s;
      level     <= level_nxt_s;
      out_valid <= (level_nxt_s != LW'(0));
      out_W     <= head_nxt_s[EW-1:N_BITS+1];
      out_N     <= head_nxt_s[N_BITS:1];
      out_match <= head_nxt_s[0];
      if (push_s) begin
        mem_r[wr_ptr_r] <= entry_s;
      end
    end
  end

  // Statistics counters count every capture whether or not it fits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pass_cnt <= CNT_W'(0);
      fail_cnt <= CNT_W'(0);
      drop_cnt <= CNT_W'(0);
      overflow <= 1'b0;
    end else begin
      if (cap_s && match_s) begin
        pass_cnt <= sat_inc(pass_cnt);
      end
      if (cap_s && !match_s) begin
        fail_cnt <= sat_inc(fail_cnt);
      end
      if (drop_s) begin
        drop_cnt <= sat_inc(drop_cnt);
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: doc/dec_result_collector.md
DEC_RESULT_COLLECTOR -- requirements
Module: dec_result_collector

Parameters
REQ-001 SHALL provide parameter W_BITS, default 39, width of the codeword tag captured alongside each result.
REQ-002 SHALL provide parameter N_BITS, default 25, width of the decoder result N.
REQ-003 SHALL provide parameter DEPTH, default 4, result FIFO entries (power of two, >=2).
REQ-004 SHALL provide parameter EXP_N, default 16777215, expected decoder result used for pass/fail classification.
REQ-005 SHALL provide parameter CNT_W, default 16, width of the statistics counters.

Interface
REQ-006 SHALL have port clk, input, 1 bit, sole clock; all state changes on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-008 SHALL have port found, input, 1 bit, decoder completion level from the upstream decoder.
REQ-009 SHALL have port N, input, N_BITS, decoder result, valid while found=1.
REQ-010 SHALL have port W, input, W_BITS, codeword presented to the decoder, held stable while found=1.
REQ-011 SHALL have port out_ready, input, 1 bit, downstream accepts the head entry.
REQ-012 SHALL have port out_valid, output, 1 bit, FIFO non-empty.
REQ-013 SHALL have port out_W, output, W_BITS, head entry tag.
REQ-014 SHALL have port out_N, output, N_BITS, head entry result.
REQ-015 SHALL have port out_match, output, 1 bit, head entry N equalled EXP_N.
REQ-016 SHALL have port level, output, clog2(DEPTH)+1 bits, current FIFO occupancy 0..DEPTH.
REQ-017 SHALL have ports pass_cnt, fail_cnt, drop_cnt, outputs, CNT_W each, statistics counters.
REQ-018 SHALL have port overflow, output, 1 bit, sticky: a capture was dropped.

Function
REQ-019 SHALL register found into found_d each cycle; capture event = found & ~found_d.
REQ-020 SHALL produce exactly one capture per found rising edge; found held high for any number of cycles yields one capture; low-then-high yields a new one.
REQ-021 SHALL on capture compute match = (N == EXP_N), full N_BITS compare, and push {W, N, match}.
REQ-022 SHALL on capture increment pass_cnt if match else fail_cnt, regardless of FIFO state, saturating at all-ones.
REQ-023 SHALL present the head entry first-word-fall-through: an entry pushed at edge k is visible on out_* with out_valid=1 after edge k (1-cycle latency).
REQ-024 SHALL pop the head at an edge where out_valid=1 and out_ready=1; out_* must stay stable while out_valid=1 and out_ready=0.
REQ-025 SHALL drive out_W, out_N, out_match to 0 while out_valid=0.
REQ-026 SHALL when full (level=DEPTH) accept a capture only if a pop occurs on the same edge; level then stays DEPTH.
REQ-027 SHALL when full without a same-edge pop drop the capture, increment drop_cnt (saturating) and set overflow until reset.
REQ-028 SHALL when empty with a capture not pop on that edge (out_valid=0); level becomes 1.
REQ-029 SHALL wrap read/write pointers modulo DEPTH; level changes by +1 push-only, -1 pop-only, 0 both or neither.

Reset
REQ-030 SHALL on rst=1, immediately and independent of clk, clear found_d, pointers, level, out_valid, out_W, out_N, out_match, pass_cnt, fail_cnt, drop_cnt, overflow to 0.
REQ-031 SHALL discard all FIFO contents on reset mid-operation; no partial entry survives.
REQ-032 SHALL, if found=1 at the first rising edge after rst deasserts, treat it as a capture (found_d reset 0).

Verification
REQ-033 Single result: W=5, N=16777215, found 0->1 held 3 cycles -> one entry, out_valid after 1 edge, out_match=1, pass_cnt=1, fail_cnt=0.
REQ-034 Mismatch: N=123 on found rise -> out_match=0, fail_cnt=1, out_N=123.
REQ-035 Backpressure/overflow: out_ready=0, 5 captures with DEPTH=4 -> level=4, drop_cnt=1, overflow=1, pass_cnt+fail_cnt=5; then out_ready=1 -> first four W values in order, level 0.
REQ-036 Full with simultaneous pop: level=4, capture and pop same edge -> level stays 4, drop_cnt unchanged, new entry at tail.
REQ-037 Reset mid-stream: 2 entries queued, rst pulse between edges -> out_valid, level, all counters 0 immediately; with found=1 at release -> one new capture.
REQ-038 Saturation: CNT_W=4, 17 matching captures with out_ready=1 -> pass_cnt=15.
